// File: rtl/pattern_recorder_pkg.sv
// rtl/pattern_recorder_pkg.sv - shared types and sizes for the pattern record/playback path
// Holds the recorder state enum and the default divider/RAM geometry used by both sides.
package pattern_recorder_pkg;

    localparam int DEFAULT_DIV = 25;
    localparam int PAT_DEPTH   = 32;
    localparam int PAT_AW      = 5;
    localparam int PAT_DW      = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_DONE = 2'd2
    } rec_state_e;

endpackage

// File: rtl/pattern_recorder_if.sv
// rtl/pattern_recorder_if.sv - pattern RAM write port bundle
// Signals: WE (one-cycle write strobe), WADDR (word address), WDATA (word data).
// master drives the write port (recorder), slave receives it (RAM).
interface pattern_recorder_if
    import pattern_recorder_pkg::*;
#(
    parameter int AW = PAT_AW,
    parameter int DW = PAT_DW
);
    logic          WE;
    logic [AW-1:0] WADDR;
    logic [DW-1:0] WDATA;

    modport master (output WE, output WADDR, output WDATA);
    modport slave  (input  WE, input  WADDR, input  WDATA);
endinterface

// File: rtl/pattern_recorder_tick_div.sv
// rtl/pattern_recorder_tick_div.sv - divide-by-DIV rate enable
// Ports: clk, rst_n (async active-low), clr (sync clear), en (count enable),
//        tick (high for one cycle when the count sits at DIV-1 while enabled).
// The count is held at zero whenever en is low.
module pattern_recorder_tick_div #(
    parameter int DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_top;

    assign at_top = (cnt_q == CW'(DIV - 1));
    assign tick   = en && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (at_top) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pattern_recorder.sv
// rtl/pattern_recorder.sv - records switch samples into the pattern RAM at the divided rate
// Ports: CLK, RESET (async active-low), START/STOP (level-sampled controls),
//        DIN (sample data), ram (RAM write port, master), BUSY (recording),
//        DONE (finished), LEN (words written in the last/current recording).
// All outputs are registered.
module pattern_recorder
    import pattern_recorder_pkg::*;
#(
    parameter int div_by = DEFAULT_DIV,
    parameter int DEPTH  = PAT_DEPTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int DW     = PAT_DW
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic                STOP,
    input  logic [DW-1:0]       DIN,
    pattern_recorder_if.master  ram,
    output logic                BUSY,
    output logic                DONE,
    output logic [AW:0]         LEN
);
    rec_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          tick;
    logic          last_addr;

    pattern_recorder_tick_div #(.DIV(div_by)) u_tick_div (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (accept),
        .en    (state_q == ST_REC),
        .tick  (tick)
    );

    assign last_addr = (addr_q == AW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = ST_REC;
                    addr_d  = '0;
                    len_d   = '0;
                end
            end
            ST_REC: begin
                if (tick) begin
                    // The sample in flight is always written, even when STOP
                    // arrives on the same cycle.
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = DIN;
                    addr_d  = last_addr ? '0 : addr_q + 1'b1;
                    len_d   = len_q + 1'b1;
                    if (last_addr || STOP) begin
                        state_d = ST_DONE;
                    end
                end else if (STOP) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status flags track the next state so they line up with state_q.
        busy_d = (state_d == ST_REC);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ram.WE    = we_q;
    assign ram.WADDR = waddr_q;
    assign ram.WDATA = wdata_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign LEN       = len_q;
endmodule
